// File: rtl/mmio_port_bank_pkg.sv
// Shared register map for the MMIO port bank: per-channel offsets, stride and global offsets.
package mmio_port_bank_pkg;

    localparam logic [3:0] OFF_OUT = 4'h0;
    localparam logic [3:0] OFF_SET = 4'h4;
    localparam logic [3:0] OFF_CLR = 4'h8;
    localparam logic [3:0] OFF_IN  = 4'hC;

    localparam int CH_STRIDE = 16;

    // Global block starts right after the last channel.
    localparam logic [3:0] OFF_CHG = 4'h0;
    localparam logic [3:0] OFF_IEN = 4'h4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_SET,
        SEL_CLR,
        SEL_IN,
        SEL_CHG,
        SEL_IEN
    } reg_sel_e;

endpackage

// File: rtl/port_sync_chg.sv
// One input channel: two-flop synchronizer plus a previous-value flop for change detection.
module port_sync_chg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             change_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o   = s2_q;
    assign change_o = (s2_q != prev_q);

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of NCH output/input ports with sticky change flags and one interrupt.
// Address decode, output/global registers and irq live here; input sampling is per channel.
module mmio_port_bank
    import mmio_port_bank_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h800
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rdata,
    output logic                 hit,
    input  logic [NCH*WIDTH-1:0] in_pins,
    output logic [NCH*WIDTH-1:0] out_pins,
    output logic                 irq
);

    localparam logic [29:0] BASE_WORD  = BASE_ADDR[31:2];
    localparam logic [29:0] CHAN_WORDS = 30'(NCH * CH_STRIDE / 4);
    localparam logic [29:0] CHG_WORD   = CHAN_WORDS + 30'(OFF_CHG >> 2);
    localparam logic [29:0] IEN_WORD   = CHAN_WORDS + 30'(OFF_IEN >> 2);

    logic [29:0]                 wordAddr;
    logic [29:0]                 wordOff;
    reg_sel_e                    sel;
    logic [2:0]                  chSel;
    logic                        wrEn;

    logic [NCH-1:0][WIDTH-1:0]   outVal_q;
    logic [NCH-1:0][WIDTH-1:0]   outVal_d;
    logic [NCH-1:0][WIDTH-1:0]   syncVal;
    logic [NCH-1:0]              chg_q;
    logic [NCH-1:0]              chg_d;
    logic [NCH-1:0]              ien_q;
    logic [NCH-1:0]              ien_d;
    logic [NCH-1:0]              chgPulse;
    logic                        irq_q;
    logic                        irq_d;

    // Byte-lane bits and the read strobe carry no information for this bank.
    logic unusedBits;
    assign unusedBits = ^{addr[1:0], re, wdata};

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        port_sync_chg #(
            .WIDTH(WIDTH)
        ) u_sync (
            .clk_i   (clk),
            .reset_i (reset),
            .pin_i   (in_pins[c*WIDTH +: WIDTH]),
            .sync_o  (syncVal[c]),
            .change_o(chgPulse[c])
        );
    end

    always_comb begin
        wordAddr = addr[31:2];
        wordOff  = wordAddr - BASE_WORD;
        sel      = SEL_NONE;
        chSel    = '0;
        if (wordAddr >= BASE_WORD) begin
            if (wordOff < CHAN_WORDS) begin
                chSel = wordOff[4:2];
                case (wordOff[1:0])
                    OFF_OUT[3:2]: sel = SEL_OUT;
                    OFF_SET[3:2]: sel = SEL_SET;
                    OFF_CLR[3:2]: sel = SEL_CLR;
                    OFF_IN[3:2]:  sel = SEL_IN;
                    default:      sel = SEL_NONE;
                endcase
            end else if (wordOff == CHG_WORD) begin
                sel = SEL_CHG;
            end else if (wordOff == IEN_WORD) begin
                sel = SEL_IEN;
            end
        end
        hit = (sel != SEL_NONE);
    end

    // New changes are OR-ed in after the write-1-to-clear so a same-edge change survives.
    always_comb begin
        outVal_d = outVal_q;
        chg_d    = chg_q;
        ien_d    = ien_q;
        wrEn     = we && hit;
        for (int c = 0; c < NCH; c++) begin
            if (wrEn && chSel == 3'(c)) begin
                case (sel)
                    SEL_OUT: outVal_d[c] = wdata[WIDTH-1:0];
                    SEL_SET: outVal_d[c] = outVal_q[c] | wdata[WIDTH-1:0];
                    SEL_CLR: outVal_d[c] = outVal_q[c] & ~wdata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
        if (wrEn && sel == SEL_CHG) begin
            chg_d = chg_q & ~wdata[NCH-1:0];
        end
        if (wrEn && sel == SEL_IEN) begin
            ien_d = wdata[NCH-1:0];
        end
        chg_d = chg_d | chgPulse;
        irq_d = |(chg_q & ien_q);
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chSel == 3'(c)) begin
                case (sel)
                    SEL_OUT: rdata[WIDTH-1:0] = outVal_q[c];
                    SEL_IN:  rdata[WIDTH-1:0] = syncVal[c];
                    default: ;
                endcase
            end
        end
        case (sel)
            SEL_CHG: rdata[NCH-1:0] = chg_q;
            SEL_IEN: rdata[NCH-1:0] = ien_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outVal_q <= '0;
            chg_q    <= '0;
            ien_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            outVal_q <= outVal_d;
            chg_q    <= chg_d;
            ien_q    <= ien_d;
            irq_q    <= irq_d;
        end
    end

    assign out_pins = outVal_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Randomized plus directed bench for mmio_port_bank against a history-based reference model.
module tb_mmio_port_bank;

    localparam logic [31:0] BASE = 32'h800;
    localparam int          MAXE = 4096;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] in_pins;
    logic [31:0] out_pins;
    logic        irq;

    int totalCnt = 0;
    int badCnt   = 0;

    // Reference state: register contents plus a per-edge log of pins and reset.
    logic [7:0]  outM [4];
    logic [3:0]  chgM;
    logic [3:0]  ienM;
    logic        irqM;
    int          edgeCnt = 0;
    logic [31:0] pinHist [MAXE];
    logic        rstHist [MAXE];
    logic [31:0] pinsV;

    mmio_port_bank #(
        .NCH      (4),
        .WIDTH    (8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .hit     (hit),
        .in_pins (in_pins),
        .out_pins(out_pins),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalCnt++;
        if (actual !== expected) begin
            badCnt++;
            $display("[TB] FAIL %s: got %h want %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Value visible at IN after edge k: pins sampled one edge earlier, zero if reset touched either edge.
    function automatic logic [31:0] inAfter(int k);
        if (k < 2) return '0;
        if (rstHist[k] || rstHist[k-1]) return '0;
        return pinHist[k-1];
    endfunction

    function automatic logic modelHit(logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd72);
    endfunction

    function automatic logic [31:0] modelRead(logic [31:0] a);
        logic [31:0] off;
        logic [31:0] inV;
        if (!modelHit(a)) return '0;
        off = (a - BASE) & ~32'd3;
        if (off == 32'd64) return {28'b0, chgM};
        if (off == 32'd68) return {28'b0, ienM};
        if (off % 16 == 0) return {24'b0, outM[off / 16]};
        if (off % 16 == 12) begin
            inV = inAfter(edgeCnt);
            return {24'b0, inV[(off / 16) * 8 +: 8]};
        end
        return '0;
    endfunction

    task automatic modelEdge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                             input logic wr, input logic [31:0] pins);
        logic [31:0] s2b;
        logic [31:0] prevb;
        logic [31:0] off;
        int          ch;
        edgeCnt++;
        pinHist[edgeCnt] = pins;
        rstHist[edgeCnt] = rst;
        if (rst) begin
            for (int c = 0; c < 4; c++) outM[c] = '0;
            chgM = '0;
            ienM = '0;
            irqM = 1'b0;
        end else begin
            s2b   = inAfter(edgeCnt - 1);
            prevb = rstHist[edgeCnt - 1] ? 32'h0 : inAfter(edgeCnt - 2);
            irqM  = |(chgM & ienM);
            if (wr && modelHit(a)) begin
                off = (a - BASE) & ~32'd3;
                if (off < 32'd64) begin
                    ch = int'(off / 16);
                    case (off % 16)
                        0:  outM[ch] = wd[7:0];
                        4:  outM[ch] = outM[ch] | wd[7:0];
                        8:  outM[ch] = outM[ch] & ~wd[7:0];
                        default: ;
                    endcase
                end else if (off == 32'd64) begin
                    chgM = chgM & ~wd[3:0];
                end else if (off == 32'd68) begin
                    ienM = wd[3:0];
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (s2b[c*8 +: 8] != prevb[c*8 +: 8]) chgM[c] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [31:0] a, input logic [31:0] wd,
                                 input logic wr, input logic rd, input logic [31:0] pins);
        reset   = rstV;
        addr    = a;
        wdata   = wd;
        we      = wr;
        re      = rd;
        in_pins = pins;
        #1;
        checkOutput("hit", {31'b0, hit}, {31'b0, modelHit(a)});
        if (edgeCnt > 0) checkOutput("rdata", rdata, modelRead(a));
        @(posedge clk);
        modelEdge(rstV, a, wd, wr, pins);
        #1;
        checkOutput("outPins", out_pins, {outM[3], outM[2], outM[1], outM[0]});
        checkOutput("irq", {31'b0, irq}, {31'b0, irqM});
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
        addr = a;
        we   = 1'b0;
        re   = 1'b1;
        #1;
        checkOutput(tag, rdata, expected);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, pinsV);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          sel;
        $display("[TB] starting");
        pinsV = '0;

        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, pinsV);
        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, pinsV);
        checkOutput("resetOut", out_pins, 32'h0);
        checkOutput("resetIrq", {31'b0, irq}, 32'h0);

        // Output register write, set and clear on channel 1.
        applyStimulus(1'b0, BASE + 32'h10, 32'h0000_005A, 1'b1, 1'b0, pinsV);
        checkOutput("outWrite", {24'b0, out_pins[15:8]}, 32'h5A);
        applyStimulus(1'b0, BASE + 32'h14, 32'hFFFF_FF81, 1'b1, 1'b0, pinsV);
        checkOutput("outSet", {24'b0, out_pins[15:8]}, 32'hDB);
        applyStimulus(1'b0, BASE + 32'h18, 32'h0000_000F, 1'b1, 1'b0, pinsV);
        checkOutput("outClr", {24'b0, out_pins[15:8]}, 32'hD0);
        readCheck("outRead", BASE + 32'h10, 32'hD0);
        readCheck("setReadsZero", BASE + 32'h14, 32'h0);

        // Input latency and change flag on channel 2.
        pinsV[23:16] = 8'h3C;
        applyStimulus(1'b0, BASE + 32'h2C, 32'h0, 1'b0, 1'b1, pinsV);
        readCheck("inLat1", BASE + 32'h2C, 32'h0);
        idle();
        readCheck("inLat2", BASE + 32'h2C, 32'h3C);
        idle();
        readCheck("chgAfter3", BASE + 32'h40, 32'h4);

        // Interrupt follows CHG by one cycle and clears after write-1-to-clear.
        applyStimulus(1'b0, BASE + 32'h44, 32'h4, 1'b1, 1'b0, pinsV);
        applyStimulus(1'b0, BASE + 32'h40, 32'h4, 1'b1, 1'b0, pinsV);
        idle();
        pinsV[23:16] = 8'h3D;
        idle();
        idle();
        idle();
        readCheck("irqChgSet", BASE + 32'h40, 32'h4);
        checkOutput("irqNotYet", {31'b0, irq}, 32'h0);
        idle();
        checkOutput("irqRise", {31'b0, irq}, 32'h1);
        applyStimulus(1'b0, BASE + 32'h40, 32'h4, 1'b1, 1'b0, pinsV);
        readCheck("chgCleared", BASE + 32'h40, 32'h0);
        idle();
        checkOutput("irqFall", {31'b0, irq}, 32'h0);

        // Clear and new change on the same edge: the change wins.
        pinsV[15:8] = 8'h11;
        idle();
        idle();
        applyStimulus(1'b0, BASE + 32'h40, 32'h2, 1'b1, 1'b0, pinsV);
        readCheck("setWins", BASE + 32'h40, 32'h2);

        // Just past the global window, and just below the base: no hit, no effect.
        addr = BASE + 32'h48;
        we   = 1'b0;
        #1;
        checkOutput("g8Hit", {31'b0, hit}, 32'h0);
        readCheck("g8Rdata", BASE + 32'h48, 32'h0);
        applyStimulus(1'b0, BASE + 32'h48, 32'hFFFF_FFFF, 1'b1, 1'b1, pinsV);
        applyStimulus(1'b0, BASE - 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b1, pinsV);
        readCheck("g8Out", BASE + 32'h10, 32'hD0);
        readCheck("g8Ien", BASE + 32'h44, 32'h4);
        readCheck("g8Chg", BASE + 32'h40, 32'h2);

        // Reset with outputs high, flags set and a simultaneous write.
        applyStimulus(1'b0, BASE + 32'h00, 32'hFF, 1'b1, 1'b0, pinsV);
        pinsV = pinsV ^ 32'h0101_0101;
        idle();
        idle();
        idle();
        readCheck("preRstChg", BASE + 32'h40, 32'hF);
        pinsV = '0;
        applyStimulus(1'b1, BASE + 32'h00, 32'hAA, 1'b1, 1'b0, pinsV);
        checkOutput("rstOut", out_pins, 32'h0);
        checkOutput("rstIrq", {31'b0, irq}, 32'h0);
        readCheck("rstChg", BASE + 32'h40, 32'h0);
        idle();
        readCheck("noSpur1", BASE + 32'h40, 32'h0);
        idle();
        idle();
        idle();
        readCheck("noSpur4", BASE + 32'h40, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) begin
                a = BASE + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 3)) * 4
                    + 32'($urandom_range(0, 3));
            end else if (sel == 6) begin
                a = BASE + 32'h40;
            end else if (sel == 7) begin
                a = BASE + 32'h44;
            end else if (sel == 8) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'h48 : BASE - 32'h4;
            end else begin
                a = $urandom;
            end
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                pinsV[$urandom_range(0, 3) * 8 +: 8] = 8'($urandom);
            end
            applyStimulus(($urandom_range(0, 199) == 0), a, wd, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), pinsV);
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/mmio_port_bank.md
MMIO_PORT_BANK -- requirements
Module: mmio_port_bank

Interface
REQ-001 The block SHALL have these parameters:
- NCH, default 4, number of I/O channels, legal 1..8.
- WIDTH, default 8, bits per channel, legal 1..32.
- BASE_ADDR, default 32'h800, byte address of channel 0.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  CPU data address, word aligned, addr[1:0] ignored.
- wdata  in  32  CPU write data.
- we  in  1  CPU write strobe (MemWrite).
- re  in  1  CPU read strobe (MemtoReg).
- rdata  out  32  read data, combinational.
- hit  out  1  addr decodes inside the bank window.
- in_pins  in  NCH*WIDTH  asynchronous external inputs, channel c at [c*WIDTH +: WIDTH].
- out_pins  out  NCH*WIDTH  registered outputs, same packing as in_pins.
- irq  out  1  registered interrupt request.

Function
REQ-003 The address map SHALL be, for channel c at BASE_ADDR + 16*c:
- +0 OUT: read/write.
- +4 SET: write-only, OUT |= wdata.
- +8 CLR: write-only, OUT &= ~wdata.
- +C IN: read-only, synchronized input value.

REQ-004 The global registers SHALL sit at G = BASE_ADDR + 16*NCH:
- G+0 CHG: one sticky change flag per channel, bit c; write-1-to-clear.
- G+4 IEN: interrupt enable per channel, read/write.

REQ-005 hit SHALL be 1 exactly when addr[31:2] selects a word in BASE_ADDR .. G+4, independent of we and re.
REQ-006 Writes SHALL take effect on the rising clk edge where we=1 and hit=1; wdata bits above WIDTH (OUT/SET/CLR) or above NCH (CHG/IEN) SHALL be ignored.
REQ-007 Reads SHALL be combinational, zero-latency and zero-extended to 32 bits:
- SET, CLR and unmapped addresses read 0.
- rdata SHALL be 0 when hit=0.
- Reads SHALL have no side effects.
REQ-008 out_pins[c] SHALL equal OUT[c] directly from a flop, with no combinational path from addr, wdata or we.
REQ-009 Each in_pins channel SHALL pass through a 2-flop synchronizer (s1 -> s2); IN reads s2; input-to-IN latency is 2 clk edges.
REQ-010 A third flop per channel, prev, SHALL hold the previous s2. CHG[c] SHALL be set on any edge where s2[c] != prev[c].
REQ-011 When a CHG write-1-to-clear and a new change on the same channel occur on the same edge, set SHALL win and CHG[c] SHALL stay 1.
REQ-012 irq SHALL be registered and equal the OR of (CHG & IEN) from the previous edge, so irq rises 1 cycle after CHG rises.
REQ-013 we and re both asserted SHALL be legal; the read returns the pre-write value.
REQ-014 we with hit=0 SHALL change no state.

Reset
REQ-015 On the rising clk edge with reset=1, the following SHALL clear to 0: OUT, s1, s2, prev, CHG, IEN and irq. out_pins=0 from the following cycle.
REQ-016 reset SHALL override a simultaneous write.
REQ-017 CHG SHALL NOT set on the first edge after reset deasserts; prev and s2 are both 0 and equal.
REQ-018 Input changes while reset=1 SHALL be visible only after 2 edges with reset=0.

Structure
REQ-019 A shared package SHALL hold:
- register offset constants (OUT, SET, CLR, IN = 0, 4, 8, C).
- channel stride (16).
- global offsets (CHG, IEN).
REQ-020 The per-channel synchronizer plus change detector SHALL be one sub-module, port_sync_chg, instantiated NCH times; decode, registers and irq stay in the top.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- Write 0x5A to BASE+0x10 -> next cycle out_pins[15:8]=0x5A; then SET 0x81 -> 0xDB; then CLR 0x0F -> 0xD0.
- Drive in_pins ch2=0x3C -> IN at BASE+0x2C reads 0 after 1 edge and 0x3C after 2 edges; CHG=0x4 after 3 edges.
- IEN=0x4 and ch2 input changes -> irq=1 one cycle after CHG[2]=1; write 0x4 to CHG -> CHG=0 and irq=0 next cycle.
- Clear CHG[1] on the same edge ch1 changes (s2!=prev) -> CHG[1] remains 1.
- addr=BASE+0x48 with NCH=4 (G+8) -> hit=0, rdata=0; we=1 there changes no register.
- Reset asserted with OUT=0xFF and CHG=0xF -> all outputs 0, no spurious CHG after release.
